// File: rtl/csa_multiword_seq_adder_if.sv
// Handshake and data bundle for the multi-word sequential adder.
// The master issues requests and reads results; the slave is the adder itself.
interface csa_multiword_seq_adder_if #(
    parameter int WORDS = 4
);
    localparam int N = 16 * WORDS;

    logic         Start;
    logic         Sub;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         Cin;
    logic         Busy;
    logic         Done;
    logic [N-1:0] Sum;
    logic         Cout;
    logic         Ovf;

    modport master (
        output Start, Sub, A, B, Cin,
        input  Busy, Done, Sum, Cout, Ovf
    );

    modport slave (
        input  Start, Sub, A, B, Cin,
        output Busy, Done, Sum, Cout, Ovf
    );
endinterface

// File: rtl/csa_multiword_seq_adder.sv
// Wide adder/subtractor built around a single 16-bit carry-select slice.
// Operands are walked least-significant slice first; the inter-slice carry
// is held in a register so one slice is resolved per clock.
//
// state  | meaning
// -------+----------------------------------------------------------
// S_IDLE | waiting for Start; results from the last operation held
// S_RUN  | one slice added per clock, index r_idx counts 0..WORDS-1

// 16-bit carry-select adder: low byte ripples, high byte is precomputed for
// both carry-in values and selected by the low byte's carry-out.
module csa16 (
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    input  logic        i_cin,
    output logic [15:0] o_sum,
    output logic        o_cout
);
    logic [8:0] w_lo;
    logic [8:0] w_hi0;
    logic [8:0] w_hi1;

    assign w_lo   = {1'b0, i_a[7:0]}  + {1'b0, i_b[7:0]}  + {8'd0, i_cin};
    assign w_hi0  = {1'b0, i_a[15:8]} + {1'b0, i_b[15:8]};
    assign w_hi1  = {1'b0, i_a[15:8]} + {1'b0, i_b[15:8]} + 9'd1;

    assign o_sum  = {(w_lo[8] ? w_hi1[7:0] : w_hi0[7:0]), w_lo[7:0]};
    assign o_cout = w_lo[8] ? w_hi1[8] : w_hi0[8];
endmodule

module csa_multiword_seq_adder #(
    parameter int WORDS = 4
) (
    input  logic                         CLK,
    input  logic                         RST,
    csa_multiword_seq_adder_if.slave     bus
);
    localparam int N  = 16 * WORDS;
    localparam int IW = $clog2(WORDS);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [IW-1:0] r_idx;
    logic          r_carry;
    logic [N-1:0]  r_a;
    logic [N-1:0]  r_beff;
    logic [N-1:0]  r_sum;
    logic          r_cout;
    logic          r_ovf;
    logic          r_done;

    logic          w_accept;
    logic          w_last;
    logic [15:0]   w_a_slice;
    logic [15:0]   w_b_slice;
    logic [15:0]   w_s;
    logic          w_c;

    assign w_accept  = (r_state == S_IDLE) && bus.Start;
    assign w_last    = (r_idx == IW'(WORDS - 1));
    assign w_a_slice = r_a[16*r_idx +: 16];
    assign w_b_slice = r_beff[16*r_idx +: 16];

    csa16 u_slice (
        .i_a    (w_a_slice),
        .i_b    (w_b_slice),
        .i_cin  (r_carry),
        .o_sum  (w_s),
        .o_cout (w_c)
    );

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: leave IDLE on Start, return after the top slice.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (bus.Start) w_state_nxt = S_RUN;
            S_RUN:   if (w_last)    w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Operand capture, per-slice accumulation and final flag update.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_a     <= '0;
            r_beff  <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                // Subtract is folded into the operand and carry here, so the
                // run phase never needs to know which operation it is doing.
                r_a     <= bus.A;
                r_beff  <= bus.Sub ? ~bus.B : bus.B;
                r_carry <= bus.Sub ? 1'b1 : bus.Cin;
                r_idx   <= '0;
            end else if (r_state == S_RUN) begin
                r_sum[16*r_idx +: 16] <= w_s;
                r_carry               <= w_c;
                r_idx                 <= r_idx + IW'(1);
                if (w_last) begin
                    r_cout <= w_c;
                    r_ovf  <= (r_a[N-1] == r_beff[N-1]) && (w_s[15] != r_a[N-1]);
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign bus.Busy = (r_state == S_RUN);
    assign bus.Done = r_done;
    assign bus.Sum  = r_sum;
    assign bus.Cout = r_cout;
    assign bus.Ovf  = r_ovf;
endmodule

// File: tb/tb_csa_multiword_seq_adder.sv
// Self-checking bench for the multi-word sequential adder (WORDS=4, 64-bit).
module tb_csa_multiword_seq_adder;
    localparam int WORDS = 4;
    localparam int N     = 16 * WORDS;

    logic CLK;
    logic RST;
    int   n_checks;
    int   n_fail;

    csa_multiword_seq_adder_if #(.WORDS(WORDS)) bus ();

    csa_multiword_seq_adder #(.WORDS(WORDS)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the full-width operands.
    task automatic model(input logic [N-1:0] a, input logic [N-1:0] b, input logic sub,
                         input logic cin, output logic [N-1:0] s, output logic co,
                         output logic ov);
        logic [N:0] wide;
        if (sub) begin
            s  = a - b;
            co = (a >= b);
            ov = (a[N-1] != b[N-1]) && (s[N-1] != a[N-1]);
        end else begin
            wide = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
            s  = wide[N-1:0];
            co = wide[N];
            ov = (a[N-1] == b[N-1]) && (s[N-1] != a[N-1]);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // One complete operation from the IDLE state, checking timing and results.
    task automatic run_op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic sub, input logic cin);
        logic [N-1:0] es;
        logic         ec;
        logic         eo;
        int           cyc;
        int           busy_cnt;
        model(a, b, sub, cin, es, ec, eo);
        bus.Start = 1'b1;
        bus.A     = a;
        bus.B     = b;
        bus.Sub   = sub;
        bus.Cin   = cin;
        tick();
        bus.Start = 1'b0;
        bus.A     = ~a;
        bus.B     = ~b;
        bus.Sub   = ~sub;
        cyc       = 0;
        busy_cnt  = 0;
        while (!bus.Done && cyc < 20) begin
            if (bus.Busy) busy_cnt++;
            tick();
            cyc++;
        end
        chk({tag, "_latency"}, N'(cyc), N'(WORDS));
        chk({tag, "_busy"}, N'(busy_cnt), N'(WORDS));
        chk({tag, "_sum"}, bus.Sum, es);
        chk({tag, "_cout"}, N'(bus.Cout), N'(ec));
        chk({tag, "_ovf"}, N'(bus.Ovf), N'(eo));
        tick();
        chk({tag, "_done_pulse"}, N'(bus.Done), N'(0));
    endtask

    initial begin
        int           dones;
        int           cnt;
        logic [N-1:0] ra;
        logic [N-1:0] rb;
        logic         rsub;
        logic         rcin;

        n_checks  = 0;
        n_fail    = 0;
        RST       = 1'b1;
        bus.Start = 1'b0;
        bus.Sub   = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        bus.Cin   = 1'b0;
        #22;
        RST = 1'b0;
        tick();
        chk("rst_busy", N'(bus.Busy), N'(0));
        chk("rst_done", N'(bus.Done), N'(0));
        chk("rst_sum", bus.Sum, '0);
        chk("rst_cout", N'(bus.Cout), N'(0));
        chk("rst_ovf", N'(bus.Ovf), N'(0));

        run_op("wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
        run_op("sovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
        run_op("cin_x", 64'h0000_FFFF_0000_FFFF, 64'h0, 1'b0, 1'b1);
        chk("cin_x_val", bus.Sum, 64'h0000_FFFF_0001_0000);
        run_op("sub_b", 64'd5, 64'd7, 1'b1, 1'b1);
        chk("sub_b_val", bus.Sum, 64'hFFFF_FFFF_FFFF_FFFE);
        run_op("sub_nb", 64'd7, 64'd5, 1'b1, 1'b0);

        // Reset mid-operation: outputs clear at once and no Done follows.
        bus.Start = 1'b1;
        bus.A     = 64'h1234_5678_9ABC_DEF0;
        bus.B     = 64'h1111_1111_1111_1111;
        bus.Sub   = 1'b0;
        tick();
        bus.Start = 1'b0;
        tick();
        #2;
        RST = 1'b1;
        #1;
        chk("mrst_busy", N'(bus.Busy), N'(0));
        chk("mrst_done", N'(bus.Done), N'(0));
        chk("mrst_sum", bus.Sum, '0);
        chk("mrst_cout", N'(bus.Cout), N'(0));
        chk("mrst_ovf", N'(bus.Ovf), N'(0));
        @(posedge CLK);
        #3;
        RST   = 1'b0;
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.Done) dones++;
        end
        chk("mrst_no_done", N'(dones), N'(0));
        run_op("post_rst", 64'd10, 64'd20, 1'b0, 1'b0);

        // Start during RUN is dropped.
        bus.Start = 1'b1;
        bus.A     = 64'd1;
        bus.B     = 64'd2;
        bus.Sub   = 1'b0;
        bus.Cin   = 1'b0;
        tick();
        bus.Start = 1'b0;
        tick();
        bus.Start = 1'b1;
        bus.A     = 64'd9;
        bus.B     = 64'd9;
        tick();
        bus.Start = 1'b0;
        dones     = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.Done) begin
                dones++;
                chk("srun_sum", bus.Sum, 64'd3);
            end
            tick();
        end
        chk("srun_ndone", N'(dones), N'(1));

        // Back-to-back with Start held high.
        bus.Start = 1'b1;
        bus.A     = 64'd1;
        bus.B     = 64'd1;
        tick();
        bus.A = 64'd2;
        bus.B = 64'd2;
        cnt   = 0;
        while (!bus.Done && cnt < 20) begin
            tick();
            cnt++;
        end
        chk("b2b_lat1", N'(cnt), N'(WORDS));
        chk("b2b_sum1", bus.Sum, 64'd2);
        tick();
        bus.Start = 1'b0;
        bus.A     = 64'd50;
        bus.B     = 64'd50;
        chk("b2b_busy", N'(bus.Busy), N'(1));
        cnt = 1;
        while (!bus.Done && cnt < 20) begin
            tick();
            cnt++;
        end
        chk("b2b_gap", N'(cnt), N'(WORDS + 1));
        chk("b2b_sum2", bus.Sum, 64'd4);
        tick();

        // Randomized operations, with occasional extreme operands.
        for (int i = 0; i < 40; i++) begin
            ra   = {$urandom, $urandom};
            rb   = {$urandom, $urandom};
            rsub = 1'($urandom_range(0, 1));
            rcin = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0: ra = 64'h8000_0000_0000_0000;
                1: rb = 64'hFFFF_FFFF_FFFF_FFFF;
                2: rb = ra;
                default: ;
            endcase
            run_op("rand", ra, rb, rsub, rcin);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/csa_multiword_seq_adder.md
Name: csa_multiword_seq_adder

Overview:
- Multi-cycle wide-operand adder/subtractor that reuses one 16-bit carry-select adder slice, iterating least-significant slice first with a registered inter-slice carry.
- Sits directly upstream of the 16-bit carry-select adder: it sequences operand slices into that adder and collects the sum slices and carry.
- Used where operands wider than 16 bits must share one adder datapath.

Parameters:
- WORDS, 4, number of 16-bit slices; operand width N = 16*WORDS; legal range 2..16.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  asynchronous, active-high reset.
- Start  input  1  request a new operation; sampled only in IDLE.
- Sub  input  1  0 = A+B+Cin, 1 = A-B (A + ~B + 1); captured with Start.
- A  input  N  operand A; captured with Start.
- B  input  N  operand B; captured with Start.
- Cin  input  1  carry-in for add; ignored when Sub=1; captured with Start.
- Busy  output  1  high while slices are being processed.
- Done  output  1  one-cycle completion pulse.
- Sum  output  N  result; valid from the Done cycle until the next accepted Start.
- Cout  output  1  carry out of the MSB. For subtract, 1 = no borrow.
- Ovf  output  1  two's-complement signed overflow of the N-bit result.

Behaviour:
- Reset: asynchronous, active-high. On assertion, state goes to IDLE and slice index, carry register, operand registers, Busy, Done, Sum, Cout and Ovf are all cleared to 0. Reset mid-operation aborts it; no Done is produced.
- States:
  - IDLE: Busy=0.
  - RUN: Busy=1.
- Accepting an operation (edge T0, IDLE with Start=1):
  - Register A, Sub, and Beff = Sub ? ~B : B.
  - Carry register <= Sub ? 1 : Cin.
  - Slice index <= 0; go to RUN.
- Datapath: one 16-bit carry-select adder instance. Its inputs are the slice at index i of A and Beff, plus the carry register.
- Each RUN edge:
  - Sum[16i+15:16i] <= adder sum.
  - Carry register <= adder carry-out.
  - i <= i+1.
- Final slice (i = WORDS-1) at edge T_WORDS:
  - Cout <= adder carry-out.
  - Ovf <= (A[N-1] == Beff[N-1]) && (new Sum[N-1] != A[N-1]).
  - Done <= 1; state <= IDLE.
- Timing: Done is high exactly one cycle, after edge T_WORDS. Latency from Start edge to Done is WORDS cycles. Busy is high for the WORDS cycles after T0.
- Start while in RUN is ignored. Operands and Sub/Cin are not re-sampled during RUN.
- Start held high: a new operation is accepted at the edge at which Done is high (state IDLE). Sustained throughput is one result per WORDS+1 cycles.
- Accepting a new Start does not clear Sum/Cout/Ovf. Slices overwrite in place, so Sum is undefined for use until the next Done.
- Arithmetic wraps modulo 2^N. Cout and Ovf are not sticky; both are recomputed every operation.

Test Plan (WORDS=4, N=64):
- Add wrap: A=0xFFFFFFFFFFFFFFFF, B=0x1, Cin=0, Sub=0 -> Sum=0, Cout=1, Ovf=0, Done exactly 4 cycles after Start edge, Busy high 4 cycles.
- Signed overflow: A=0x7FFFFFFFFFFFFFFF, B=0x1, Cin=0 -> Sum=0x8000000000000000, Cout=0, Ovf=1. Also Cin=1 with A=0x0000FFFF0000FFFF, B=0 -> Sum=0x0000FFFF00010000 (carry crosses slice 0->1).
- Subtract: Sub=1, A=5, B=7, Cin=1 (ignored) -> Sum=0xFFFFFFFFFFFFFFFE, Cout=0 (borrow), Ovf=0. Then A=7, B=5 -> Sum=2, Cout=1.
- Start during RUN: Start A=1,B=2. Pulse Start again at cycle 2 with A=9,B=9 -> Sum=3, a single Done pulse, second request dropped.
- Reset mid-op: assert RST asynchronously (between edges) during cycle 2 of an operation -> Busy/Done/Sum/Cout/Ovf immediately 0, no Done afterwards. After release, Start A=10,B=20 -> Sum=30 after 4 cycles.
- Back-to-back: Start held high with operands changed each accept (1+1, then 2+2) -> Done pulses 5 cycles apart. Results are 2, then 4.
